// File: rtl/grayscale_stream.sv
// grayscale_stream: three-stage valid/ready RGB-to-grayscale converter.
// Per-pixel mode select (luma, average, max, green), SOF/EOL sideband
// carried with each pixel, and a saturating per-frame output pixel counter.
// Optional build macro: GRAYSCALE_ROUNDING_EN (round-half-up for modes 0/1).
module grayscale_stream #(
    parameter int unsigned P_PIXEL_DEPTH    = 24,
    parameter int unsigned P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
    parameter int unsigned P_COUNT_WIDTH    = 20
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic [P_PIXEL_DEPTH-1:0]    I_PIXEL,
    input  logic [1:0]                  I_MODE,
    input  logic                        I_SOF,
    input  logic                        I_EOL,
    input  logic                        I_VALID,
    output logic                        O_READY,
    output logic [P_SUBPIXEL_DEPTH-1:0] O_PIXEL,
    output logic                        O_SOF,
    output logic                        O_EOL,
    output logic                        O_VALID,
    input  logic                        I_READY,
    output logic [P_COUNT_WIDTH-1:0]    O_PIXEL_COUNT
);

    localparam int unsigned SW    = P_SUBPIXEL_DEPTH;
    localparam int unsigned CW    = 8;
    localparam int unsigned PW    = SW + CW;
    localparam int unsigned SUMW  = SW + 10;
    localparam int unsigned FRAC  = 8;

`ifdef GRAYSCALE_ROUNDING_EN
    localparam logic [SUMW-1:0] ROUND = SUMW'(128);
`else
    localparam logic [SUMW-1:0] ROUND = '0;
`endif

    localparam logic [1:0] MODE_LUMA = 2'd0;
    localparam logic [1:0] MODE_AVG  = 2'd1;
    localparam logic [1:0] MODE_MAX  = 2'd2;

    // Handshake and stall control
    logic s3_load;
    logic s2_load;
    logic s1_load;
    logic out_xfer;

    // Stage 1 registers
    logic          s1_valid;
    logic [1:0]    s1_mode;
    logic          s1_sof;
    logic          s1_eol;
    logic [PW-1:0] s1_prod_r;
    logic [PW-1:0] s1_prod_g;
    logic [PW-1:0] s1_prod_b;
    logic [SW-1:0] s1_r;
    logic [SW-1:0] s1_g;
    logic [SW-1:0] s1_b;

    // Stage 2 registers
    logic            s2_valid;
    logic [1:0]      s2_mode;
    logic            s2_sof;
    logic            s2_eol;
    logic [SUMW-1:0] s2_sum;
    logic [SW-1:0]   s2_max;
    logic [SW-1:0]   s2_g;

    // Combinational datapath
    logic [SW-1:0]      in_r;
    logic [SW-1:0]      in_g;
    logic [SW-1:0]      in_b;
    logic [CW-1:0]      coef_r;
    logic [CW-1:0]      coef_g;
    logic [CW-1:0]      coef_b;
    logic [SUMW-1:0]    s1_sum;
    logic [SW-1:0]      s1_max;
    logic [SUMW-FRAC-1:0] sum_hi;
    logic [SW-1:0]      s3_result;
    logic               unused_sum_bits;

    assign in_r = I_PIXEL[3*SW-1 -: SW];
    assign in_g = I_PIXEL[2*SW-1 -: SW];
    assign in_b = I_PIXEL[SW-1:0];

    // Bubble-collapsing stall chain; ready path is combinational from I_READY
    assign s3_load  = ~O_VALID | I_READY;
    assign s2_load  = ~s2_valid | s3_load;
    assign s1_load  = ~s1_valid | s2_load;
    assign O_READY  = s1_load & ~I_RESET;
    assign out_xfer = O_VALID & I_READY;

    // Coefficient select for the weighted-sum modes
    always_comb begin
        coef_r = CW'(77);
        coef_g = CW'(150);
        coef_b = CW'(29);
        if (I_MODE == MODE_AVG) begin
            coef_r = CW'(85);
            coef_g = CW'(86);
            coef_b = CW'(85);
        end
    end

    // Weighted sum and channel max feeding stage 2
    always_comb begin
        s1_sum = SUMW'(s1_prod_r) + SUMW'(s1_prod_g) + SUMW'(s1_prod_b);
        if (s1_mode == MODE_LUMA || s1_mode == MODE_AVG) begin
            s1_sum = s1_sum + ROUND;
        end
        s1_max = s1_r;
        if (s1_g > s1_max) begin
            s1_max = s1_g;
        end
        if (s1_b > s1_max) begin
            s1_max = s1_b;
        end
    end

    // Final mode selection feeding the output stage
    assign sum_hi          = s2_sum[SUMW-1:FRAC];
    assign unused_sum_bits = ^{s2_sum[FRAC-1:0], sum_hi[SUMW-FRAC-1:SW]};

    always_comb begin
        s3_result = sum_hi[SW-1:0];
        if (s2_mode == MODE_MAX) begin
            s3_result = s2_max;
        end else if (s2_mode == 2'd3) begin
            s3_result = s2_g;
        end
    end

    // Stage 1: capture mode/sideband and channel x coefficient products
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            s1_valid  <= 1'b0;
            s1_mode   <= '0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_prod_r <= '0;
            s1_prod_g <= '0;
            s1_prod_b <= '0;
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
        end else if (s1_load) begin
            s1_valid  <= I_VALID;
            s1_mode   <= I_MODE;
            s1_sof    <= I_SOF;
            s1_eol    <= I_EOL;
            s1_prod_r <= PW'(in_r) * PW'(coef_r);
            s1_prod_g <= PW'(in_g) * PW'(coef_g);
            s1_prod_b <= PW'(in_b) * PW'(coef_b);
            s1_r      <= in_r;
            s1_g      <= in_g;
            s1_b      <= in_b;
        end
    end

    // Stage 2: weighted sum, channel max and green passthrough
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            s2_valid <= 1'b0;
            s2_mode  <= '0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_sum   <= '0;
            s2_max   <= '0;
            s2_g     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
            s2_sum   <= s1_sum;
            s2_max   <= s1_max;
            s2_g     <= s1_g;
        end
    end

    // Stage 3: output register, holds while downstream stalls
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_VALID <= 1'b0;
            O_PIXEL <= '0;
            O_SOF   <= 1'b0;
            O_EOL   <= 1'b0;
        end else if (s3_load) begin
            O_VALID <= s2_valid;
            O_PIXEL <= s3_result;
            O_SOF   <= s2_sof;
            O_EOL   <= s2_eol;
        end
    end

    // Output pixel counter: restarts at 1 on SOF transfers, saturates at all-ones
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_PIXEL_COUNT <= '0;
        end else if (out_xfer) begin
            if (O_SOF) begin
                O_PIXEL_COUNT <= P_COUNT_WIDTH'(1);
            end else if (~&O_PIXEL_COUNT) begin
                O_PIXEL_COUNT <= O_PIXEL_COUNT + P_COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_grayscale_stream.sv
// Self-checking bench for grayscale_stream (default 24-bit pixels).
// Honours GRAYSCALE_ROUNDING_EN when computing expected values.
module tb_grayscale_stream;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic [23:0] I_PIXEL;
    logic [1:0]  I_MODE;
    logic        I_SOF;
    logic        I_EOL;
    logic        I_VALID;
    logic        O_READY;
    logic [7:0]  O_PIXEL;
    logic        O_SOF;
    logic        O_EOL;
    logic        O_VALID;
    logic        I_READY;
    logic [19:0] O_PIXEL_COUNT;

    grayscale_stream dut (
        .I_CLK         (I_CLK),
        .I_RESET       (I_RESET),
        .I_PIXEL       (I_PIXEL),
        .I_MODE        (I_MODE),
        .I_SOF         (I_SOF),
        .I_EOL         (I_EOL),
        .I_VALID       (I_VALID),
        .O_READY       (O_READY),
        .O_PIXEL       (O_PIXEL),
        .O_SOF         (O_SOF),
        .O_EOL         (O_EOL),
        .O_VALID       (O_VALID),
        .I_READY       (I_READY),
        .O_PIXEL_COUNT (O_PIXEL_COUNT)
    );

    always #5 I_CLK = ~I_CLK;

`ifdef GRAYSCALE_ROUNDING_EN
    localparam logic [7:0] EXP_SMALL_G = 8'd1;
`else
    localparam logic [7:0] EXP_SMALL_G = 8'd0;
`endif

    typedef struct {
        logic [7:0]  pix;
        logic        sof;
        logic        eol;
        logic [19:0] cnt;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_item;
    int          checks  = 0;
    int          errors  = 0;
    int          next_id = 0;
    logic [19:0] sb_cnt  = '0;
    logic [19:0] cur_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion for one pixel
    function automatic logic [7:0] gray(input logic [23:0] px, input logic [1:0] m);
        int r, g, b, s;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        case (m)
            2'd0: s = 77 * r + 150 * g + 29 * b;
            2'd1: s = 85 * r + 86 * g + 85 * b;
            2'd2: begin
                s = r;
                if (g > s) s = g;
                if (b > s) s = b;
            end
            default: s = g;
        endcase
        if (m < 2'd2) begin
`ifdef GRAYSCALE_ROUNDING_EN
            s = s + 128;
`endif
            s = s / 256;
        end
        return 8'(s);
    endfunction

    // Drive one pixel, wait (bounded) for acceptance, record the expectation
    task automatic send(input logic [23:0] px, input logic [1:0] m, input logic sof,
                        input logic eol, input logic [7:0] exp);
        exp_t e;
        int   waitc = 0;
        I_PIXEL = px;
        I_MODE  = m;
        I_SOF   = sof;
        I_EOL   = eol;
        I_VALID = 1'b1;
        @(negedge I_CLK);
        while (!O_READY && waitc < 100) begin
            @(negedge I_CLK);
            waitc++;
        end
        if (!O_READY) begin
            chk("send_timeout", 32'(O_READY), 32'd1);
        end else begin
            sb_cnt  = sof ? 20'd1 : ((&sb_cnt) ? sb_cnt : sb_cnt + 20'd1);
            e.pix   = exp;
            e.sof   = sof;
            e.eol   = eol;
            e.cnt   = sb_cnt;
            e.id    = next_id;
            next_id++;
            sbq.push_back(e);
        end
        @(posedge I_CLK);
        #1;
        I_VALID = 1'b0;
        I_SOF   = 1'b0;
        I_EOL   = 1'b0;
    endtask

    // Output monitor: counter check every cycle, scoreboard pop on each transfer
    always @(negedge I_CLK) begin
        if (I_RESET) begin
            cur_cnt = '0;
        end else begin
            chk("count", 32'(O_PIXEL_COUNT), 32'(cur_cnt));
            if (O_VALID && I_READY) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 32'(O_VALID), 32'd0);
                end else begin
                    mon_item = sbq.pop_front();
                    chk($sformatf("pix%0d", mon_item.id), 32'(O_PIXEL), 32'(mon_item.pix));
                    chk($sformatf("sof%0d", mon_item.id), 32'(O_SOF), 32'(mon_item.sof));
                    chk($sformatf("eol%0d", mon_item.id), 32'(O_EOL), 32'(mon_item.eol));
                    cur_cnt = mon_item.cnt;
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        logic       fell;
        int         waitc;

        I_RESET = 1'b1;
        I_PIXEL = '0;
        I_MODE  = '0;
        I_SOF   = 1'b0;
        I_EOL   = 1'b0;
        I_VALID = 1'b0;
        I_READY = 1'b1;

        // Reset state
        #2;
        chk("rst_valid", 32'(O_VALID), 32'd0);
        chk("rst_ready", 32'(O_READY), 32'd0);
        chk("rst_pixel", 32'(O_PIXEL), 32'd0);
        chk("rst_sof",   32'(O_SOF),   32'd0);
        chk("rst_eol",   32'(O_EOL),   32'd0);
        chk("rst_count", 32'(O_PIXEL_COUNT), 32'd0);
        repeat (2) @(posedge I_CLK);
        #1;
        I_RESET = 1'b0;
        @(posedge I_CLK);
        #1;

        // Luma latency and single-cycle valid
        send(24'hFF7F00, 2'd0, 1'b0, 1'b0, 8'h97);
        chk("lat_k0_valid", 32'(O_VALID), 32'd0);
        @(posedge I_CLK); #1;
        chk("lat_k1_valid", 32'(O_VALID), 32'd0);
        @(posedge I_CLK); #1;
        chk("lat_k2_valid", 32'(O_VALID), 32'd1);
        chk("lat_k2_pixel", 32'(O_PIXEL), 32'h97);
        @(posedge I_CLK); #1;
        chk("single_cycle_valid", 32'(O_VALID), 32'd0);

        // Average, full scale, and small-value truncation/rounding
        send(24'h1E3C5A, 2'd1, 1'b0, 1'b0, 8'd60);
        send(24'hFFFFFF, 2'd1, 1'b0, 1'b0, 8'd255);
        send(24'h000001, 2'd0, 1'b0, 1'b0, 8'd0);
        send(24'h000100, 2'd0, 1'b0, 1'b0, EXP_SMALL_G);
        repeat (4) @(posedge I_CLK);
        #1;

        // Per-pixel mode switching back-to-back
        send(24'h0C63C8, 2'd2, 1'b0, 1'b0, 8'd200);
        send(24'h0C63C8, 2'd3, 1'b0, 1'b0, 8'd99);
        send(24'h0C63C8, 2'd2, 1'b0, 1'b0, 8'd200);
        send(24'h0C63C8, 2'd3, 1'b0, 1'b0, 8'd99);
        send(24'h0C63C8, 2'd0, 1'b0, 1'b0, 8'd84);
        repeat (4) @(posedge I_CLK);
        #1;

        // Backpressure: 6-pixel stream with a 4-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [23:0] px;
                    px = 24'(32'h1F2E3D * (i + 1));
                    send(px, 2'(i % 4), 1'b0, 1'b0, gray(px, 2'(i % 4)));
                end
            end
            begin
                waitc = 0;
                @(negedge I_CLK);
                while (!O_VALID && waitc < 50) begin
                    @(negedge I_CLK);
                    waitc++;
                end
                chk("stall_first_valid", 32'(O_VALID), 32'd1);
                @(posedge I_CLK); #1;
                I_READY = 1'b0;
                @(negedge I_CLK);
                held = O_PIXEL;
                fell = ~O_READY;
                repeat (3) begin
                    @(negedge I_CLK);
                    chk("stall_hold_pixel", 32'(O_PIXEL), 32'(held));
                    chk("stall_hold_valid", 32'(O_VALID), 32'd1);
                    if (!O_READY) fell = 1'b1;
                end
                chk("stall_ready_fell", 32'(fell), 32'd1);
                @(posedge I_CLK); #1;
                I_READY = 1'b1;
            end
        join
        repeat (6) @(posedge I_CLK);
        #1;

        // Sideband alignment and frame counter 1,2,3,4,1
        send(24'h001100, 2'd3, 1'b1, 1'b0, 8'h11);
        send(24'h002200, 2'd3, 1'b0, 1'b0, 8'h22);
        send(24'h003300, 2'd3, 1'b0, 1'b0, 8'h33);
        send(24'h004400, 2'd3, 1'b0, 1'b1, 8'h44);
        send(24'h005500, 2'd3, 1'b1, 1'b0, 8'h55);
        repeat (5) @(posedge I_CLK);
        #1;
        chk("frame_count_restart", 32'(O_PIXEL_COUNT), 32'd1);

        // Asynchronous reset with pixels in flight
        send(24'h00AA00, 2'd3, 1'b0, 1'b0, 8'hAA);
        send(24'h00BB00, 2'd3, 1'b0, 1'b0, 8'hBB);
        @(posedge I_CLK);
        #3;
        chk("pre_rst_valid", 32'(O_VALID), 32'd1);
        I_RESET = 1'b1;
        #1;
        chk("async_rst_valid", 32'(O_VALID), 32'd0);
        chk("async_rst_pixel", 32'(O_PIXEL), 32'd0);
        chk("async_rst_count", 32'(O_PIXEL_COUNT), 32'd0);
        chk("async_rst_ready", 32'(O_READY), 32'd0);
        sbq.delete();
        sb_cnt = '0;
        repeat (2) @(posedge I_CLK);
        #1;
        I_RESET = 1'b0;
        repeat (5) begin
            @(negedge I_CLK);
            chk("post_rst_idle", 32'(O_VALID), 32'd0);
        end
        @(posedge I_CLK);
        #1;
        send(24'h00CC00, 2'd3, 1'b0, 1'b0, 8'hCC);

        // Drain
        waitc = 0;
        while (sbq.size() != 0 && waitc < 50) begin
            @(negedge I_CLK);
            waitc++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        repeat (2) @(posedge I_CLK);
        #1;
        chk("final_count", 32'(O_PIXEL_COUNT), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grayscale_stream.md
Name: grayscale_stream

Overview:
Pipelined, parametrised successor to the single-pixel grayscale converter. It accepts packed RGB pixels over a valid/ready stream and emits one grayscale subpixel per input pixel. Conversion mode is selectable per pixel, frame/line sideband flags pass through aligned with the data, and an output pixel counter is maintained per frame. It sits between the pixel input interface and the edge-detection filter stages.

Parameters:
P_PIXEL_DEPTH, 24, packed RGB width; R = [MSB third], G = middle third, B = [LSB third]; must be divisible by 3
P_SUBPIXEL_DEPTH, P_PIXEL_DEPTH/3, width of each channel and of O_PIXEL
P_COUNT_WIDTH, 20, width of O_PIXEL_COUNT

Ports:
I_CLK  in  1  clock; all logic on rising edge
I_RESET  in  1  asynchronous, active-high reset
I_PIXEL  in  P_PIXEL_DEPTH  packed {R,G,B} input pixel
I_MODE  in  2  conversion mode, sampled with the pixel on accept
I_SOF  in  1  start-of-frame flag for this pixel
I_EOL  in  1  end-of-line flag for this pixel
I_VALID  in  1  input pixel valid
O_READY  out  1  block can accept the input pixel this cycle
O_PIXEL  out  P_SUBPIXEL_DEPTH  grayscale result
O_SOF  out  1  SOF flag aligned with O_PIXEL
O_EOL  out  1  EOL flag aligned with O_PIXEL
O_VALID  out  1  output valid
I_READY  in  1  downstream accepts output
O_PIXEL_COUNT  out  P_COUNT_WIDTH  number of output transfers since and including the last O_SOF transfer

Behaviour:
- Reset: one clock, I_CLK; I_RESET is asynchronous and active-high. While asserted: all stage valids 0, O_VALID=0, O_PIXEL=0, O_SOF=0, O_EOL=0, O_PIXEL_COUNT=0, O_READY=0. Reset mid-stream discards all in-flight pixels, with no partial output.
- Accept: input transfer when I_VALID & O_READY on a rising edge. Output transfer when O_VALID & I_READY.
- Pipeline: 3 registered stages S1→S2→S3, where S3 drives the outputs. Each stage carries valid, mode, SOF and EOL.
  - S1 registers the three channel×coefficient products.
  - S2 registers the weighted sum (P_SUBPIXEL_DEPTH+10 bits, no overflow), max(R,G,B) and G.
  - S3 registers the selected/shifted result.
- Stall rule, bubble-collapsing: S3 loads when !O_VALID | I_READY. S2 loads when S2 is empty or S3 loads. S1 loads when S1 is empty or S2 loads. O_READY = S1 can load, with a combinational ready path.
- Latency: a pixel accepted on edge k appears on the outputs after edge k+2 if no stalls occur. Sustained throughput is 1 pixel/clock with I_READY held high.
- While O_VALID=1 and I_READY=0, O_PIXEL, O_SOF and O_EOL hold stable. No pixel is dropped, duplicated or reordered.
- Modes (coefficients are 8 fractional bits):
  - 0: BT.601 luma, (77R+150G+29B)>>8
  - 1: average, (85R+86G+85B)>>8
  - 2: max(R,G,B)
  - 3: G passthrough
- Coefficients sum to 256, so modes 0/1 never exceed the maximum subpixel value and no saturation is needed.
- A mode change applies only to pixels accepted after the change. Pixels in flight keep their captured mode.
- Counter: on each output transfer, O_PIXEL_COUNT becomes 1 if O_SOF=1, else count+1. It saturates at all-ones. It updates only on transfers.

Optional Feature:
GRAYSCALE_ROUNDING_EN:
- Defined: modes 0/1 add 128 before the >>8 (round-half-up). Bounded: 255·256+128 still yields 255.
- Undefined: modes 0/1 truncate.
- Modes 2/3 are unaffected either way. Latency is identical in both builds.

Test Plan:
1. Mode 0, I_PIXEL={FF,7F,00}, I_READY=1 → O_PIXEL=151 (0x97) after edge k+2 (both builds); O_VALID high for exactly one cycle.
2. Mode 1, {1E,3C,5A} → 60 (0x3C); {FF,FF,FF} → 255; mode 0 with {00,00,01} → 0 without rounding, 0 with rounding. Mode 0 {00,01,00}: 150>>8 → 0 truncating, 1 with GRAYSCALE_ROUNDING_EN.
3. Pixel {0C,63,C8}: mode 2 → 200, mode 3 → 99. Send them back-to-back with I_MODE switching every cycle; outputs must match each pixel's own mode.
4. Backpressure: stream 6 pixels continuously and drop I_READY for 4 cycles after the first O_VALID → O_PIXEL stable while stalled, O_READY falls once S1–S3 are full, all 6 outputs arrive in order with no duplicates.
5. Sideband/count: 4 pixels, SOF on the 1st, EOL on the 4th, then a new SOF pixel → O_PIXEL_COUNT = 1,2,3,4,1; O_SOF/O_EOL aligned with the correct outputs.
6. Assert I_RESET asynchronously (mid-cycle) with 2 pixels in flight → O_VALID, O_PIXEL and O_PIXEL_COUNT go to 0 immediately; after release, no output until a new input is accepted.
